fetch_unit: RTL and testbench

- Instruction fetch front end: owns the PC, issues word reads to instruction memory, buffers returned words in program order, and presents them to the main/ALU decoder.
- Produces the instruction stream that the decoder consumes; the decoder reads op_code, func3 and func7 from instr.
- Handles control-flow redirects by flushing the buffer and discarding stale in-flight responses.

---
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, imem read issue, in-order buffer, redirect.
// Ports: clk/rst_n, imem req/rsp, redirect_valid/pc, instr_valid/ready/instr/pc.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(BUF_DEPTH * 2) + 1;

  typedef enum logic {BOOT, RUN} state_t;

  state_t               state;
  logic [31:0]          pc;
  logic [31:0]          ent_pc   [BUF_DEPTH];
  logic [31:0]          ent_data [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] ent_filled;
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [PW-1:0]        fptr;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        unf;
  logic [DW-1:0]        drop_cnt;
  logic                 out_valid;
  logic [31:0]          out_instr;
  logic [31:0]          out_pc;

  logic          pop;
  logic          acc;
  logic          drop_now;
  logic          fill_now;
  logic [PW-1:0] head_n;
  logic          fill_head_n;
  logic          nxt_filled;
  logic [31:0]   nxt_data;
  logic          unused_ok;

  assign unused_ok = ^redirect_pc[1:0];

  always_comb begin
    pop            = out_valid && instr_ready;
    imem_req_valid = (state == RUN) && !redirect_valid &&
                     ((cnt - CW'(pop)) < CW'(BUF_DEPTH));
    acc            = imem_req_valid && imem_req_ready;
    drop_now       = imem_rsp_valid && (drop_cnt != '0);
    fill_now       = imem_rsp_valid && (drop_cnt == '0) &&
                     (unf != '0);
    head_n         = head + PW'(pop);
    // Output registers track the head as it will be after this edge
    fill_head_n    = fill_now && (fptr == head_n);
    nxt_filled     = ent_filled[head_n] || fill_head_n;
    nxt_data       = fill_head_n ? imem_rsp_data
                                 : ent_data[head_n];
  end

  assign imem_req_addr = pc;
  assign instr_valid   = out_valid;
  assign instr         = out_instr;
  assign instr_pc      = out_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      head       <= '0;
      tail       <= '0;
      fptr       <= '0;
      cnt        <= '0;
      unf        <= '0;
      drop_cnt   <= '0;
      ent_filled <= '0;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_pc     <= '0;
    end else begin
      state <= RUN;
      if (redirect_valid) begin
        pc         <= {redirect_pc[31:2], 2'b00};
        head       <= '0;
        tail       <= '0;
        fptr       <= '0;
        cnt        <= '0;
        unf        <= '0;
        ent_filled <= '0;
        out_valid  <= 1'b0;
        // Every unfilled request still owes a response we must eat
        drop_cnt   <= drop_cnt - DW'(drop_now)
                    + DW'(unf) - DW'(fill_now);
      end else begin
        if (acc) begin
          pc   <= pc + 32'd4;
          tail <= tail + PW'(1);
        end
        head     <= head_n;
        fptr     <= fptr + PW'(fill_now);
        cnt      <= cnt + CW'(acc) - CW'(pop);
        unf      <= unf + CW'(acc) - CW'(fill_now);
        drop_cnt <= drop_cnt - DW'(drop_now);
        if (pop)
          ent_filled[head] <= 1'b0;
        if (fill_now)
          ent_filled[fptr] <= 1'b1;
        out_valid <= nxt_filled;
        if (nxt_filled) begin
          out_instr <= nxt_data;
          out_pc    <= ent_pc[head_n];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc)
      ent_pc[tail] <= pc;
    if (fill_now && !redirect_valid)
      ent_data[fptr] <= imem_rsp_data;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order latency memory model.
// Ports: none; drives every DUT port and prints one summary line.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hC0DE_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .BUF_DEPTH(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc)
  );

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] acc_log[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_dat[$];
  int          cyc;
  int          lat;
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (imem_req_valid && imem_req_ready) begin
      mq.push_back('{cyc + lat, imem_req_addr});
      acc_log.push_back(imem_req_addr);
    end
    if (instr_valid && instr_ready) begin
      got_pc.push_back(instr_pc);
      got_dat.push_back(instr);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = dat(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    mq.delete();
    acc_log.delete();
    got_pc.delete();
    got_dat.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    cyc            = 0;
    lat            = 1;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;

    // reset values
    #12;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);

    // run after reset, latency 1
    do_reset();
    #1;
    chk("boot_no_req", imem_req_valid, 0);
    tick();
    chk("run_req_valid", imem_req_valid, 1);
    chk("run_req_addr0", imem_req_addr, 32'h0);
    tick();
    chk("run_c2_ivalid", instr_valid, 0);
    chk("run_req_addr4", imem_req_addr, 32'h4);
    tick();
    chk("run_c3_ivalid", instr_valid, 1);
    chk("run_c3_pc", instr_pc, 32'h0);
    chk("run_c3_instr", instr, dat(32'h0));
    tick();
    chk("run_c4_pc", instr_pc, 32'h4);
    tick();
    chk("run_c5_pc", instr_pc, 32'h8);

    // decoder backpressure
    instr_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    chk("bp_req_count", acc_log.size(), 4);
    chk("bp_last_addr", acc_log[3], 32'hC);
    chk("bp_req_valid", imem_req_valid, 0);
    chk("bp_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    repeat (8) tick();
    chk("bp_got_count", got_pc.size() >= 5, 1);
    chk("bp_got0", got_pc[0], 32'h0);
    chk("bp_got1", got_pc[1], 32'h4);
    chk("bp_got2", got_pc[2], 32'h8);
    chk("bp_got3", got_pc[3], 32'hC);
    chk("bp_dat3", got_dat[3], dat(32'hC));
    chk("bp_got4", got_pc[4], 32'h10);

    // memory request stall
    do_reset();
    repeat (5) tick();
    chk("st_addr_pre", imem_req_addr, 32'h10);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st_valid", imem_req_valid, 1);
      chk("st_addr", imem_req_addr, 32'h10);
    end
    imem_req_ready = 1'b1;
    tick();
    chk("st_addr_post", imem_req_addr, 32'h14);
    chk("st_acc_count", acc_log.size(), 5);

    // redirect with two responses outstanding
    lat = 3;
    do_reset();
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    #1;
    chk("rd_req_drop", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("rd_req_valid", imem_req_valid, 1);
    chk("rd_req_addr", imem_req_addr, 32'h100);
    chk("rd_ivalid", instr_valid, 0);
    repeat (8) tick();
    chk("rd_got_count", got_pc.size() >= 2, 1);
    chk("rd_got0", got_pc[0], 32'h100);
    chk("rd_dat0", got_dat[0], dat(32'h100));
    chk("rd_got1", got_pc[1], 32'h104);
    chk("rd_acc2", acc_log[2], 32'h100);

    // redirect coinciding with response and consume
    lat = 1;
    do_reset();
    repeat (3) tick();
    chk("co_rsp_live", imem_rsp_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("co_c4_ivalid", instr_valid, 0);
    chk("co_c4_addr", imem_req_addr, 32'h200);
    tick();
    chk("co_c5_ivalid", instr_valid, 0);
    tick();
    chk("co_c6_ivalid", instr_valid, 1);
    chk("co_c6_pc", instr_pc, 32'h200);
    chk("co_c6_instr", instr, dat(32'h200));
    repeat (3) tick();
    chk("co_got_count", got_pc.size() >= 3, 1);
    chk("co_got0", got_pc[0], 32'h0);
    chk("co_got1", got_pc[1], 32'h200);
    chk("co_got2", got_pc[2], 32'h204);

    // asynchronous reset mid-stream
    instr_ready = 1'b0;
    do_reset();
    repeat (4) tick();
    imem_req_ready = 1'b0;
    tick();
    chk("ar_pre_ivalid", instr_valid, 1);
    chk("ar_pre_req", imem_req_valid, 1);
    chk("ar_pre_addr", imem_req_addr, 32'hC);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ivalid", instr_valid, 0);
    chk("ar_req", imem_req_valid, 0);
    chk("ar_instr_pc", instr_pc, 32'h0);
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    do_reset();
    repeat (3) tick();
    chk("ar_restart_acc", acc_log[0], 32'h0);
    chk("ar_restart_iv", instr_valid, 1);
    chk("ar_restart_pc", instr_pc, 32'h0);

    // redirect during boot, pc wrap
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF9;
    #1;
    chk("bt_no_req", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("bt_req_valid", imem_req_valid, 1);
    chk("bt_req_addr", imem_req_addr, 32'hFFFF_FFF8);
    repeat (6) tick();
    chk("wr_got_count", got_pc.size() >= 3, 1);
    chk("wr_got0", got_pc[0], 32'hFFFF_FFF8);
    chk("wr_got1", got_pc[1], 32'hFFFF_FFFC);
    chk("wr_got2", got_pc[2], 32'h0);
    chk("wr_dat2", got_dat[2], dat(32'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
